// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed seven-segment driver with frame-synchronous double buffering
// Optional ghost blanking after each digit change: define SEG_BLANK_EN.
module seg7_scan_driver #(
  parameter int CYCLES_PER_SECOND = 100_000_000,
  parameter int SCAN_HZ           = 1000,
  parameter int BLANK_CYCLES      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seven_segment,
  output logic        frame_start
);

  localparam int DIV = CYCLES_PER_SECOND / SCAN_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("seg7_scan_driver: CYCLES_PER_SECOND/SCAN_HZ must be at least 2");
    end
  endgenerate

  function automatic logic [6:0] hexdec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [19:0]   shadow;    // {digits, digit_en}
  logic [19:0]   active;
  logic [19:0]   active_nxt;
  logic          tick;
  logic          boundary;
  logic          en_bit;
  logic [3:0]    nib;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          blank_now;

  assign tick     = (prescaler == PW'(DIV - 1));
  assign boundary = tick && (idx == 2'd3);
  assign idx_nxt  = tick ? idx + 2'd1 : idx;

  // A load coincident with the boundary bypasses the shadow so it is not lost for a frame.
  assign active_nxt = boundary ? (load ? {digits, digit_en} : shadow) : active;

  always_comb begin
    en_bit = active_nxt[idx_nxt];
    case (idx_nxt)
      2'd0:    nib = active_nxt[7:4];
      2'd1:    nib = active_nxt[11:8];
      2'd2:    nib = active_nxt[15:12];
      default: nib = active_nxt[19:16];
    endcase
    an_nxt          = 4'b1111;
    an_nxt[idx_nxt] = ~en_bit;
    seg_nxt         = en_bit ? hexdec(nib) : 7'h7F;
  end

`ifdef SEG_BLANK_EN
  localparam int BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  generate
    if (BLANK_CYCLES >= DIV) begin : g_blank_check
      $error("seg7_scan_driver: BLANK_CYCLES must be less than the scan divider");
    end
  endgenerate

  logic [PW-1:0] blank_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_cnt <= '0;
    end else if (tick) begin
      blank_cnt <= PW'(BLANK_LOAD);
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - 1'b1;
    end
  end

  assign blank_now = (tick && (BLANK_CYCLES > 0)) || (blank_cnt != '0);
`else
  assign blank_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= 2'd0;
      shadow    <= '0;
      active    <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      idx       <= idx_nxt;
      active    <= active_nxt;
      if (load) begin
        shadow <= {digits, digit_en};
      end
    end
  end

  // Outputs track the post-tick idx/active, so they change on the same edge as idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an            <= 4'b1111;
      seven_segment <= 7'h7F;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (blank_now) begin
        an            <= 4'b1111;
        seven_segment <= 7'h7F;
      end else begin
        an            <= an_nxt;
        seven_segment <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized and directed self-checking bench for seg7_scan_driver
// Reference model derives the display purely from elapsed cycle count and the load history.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;
`ifdef SEG_BLANK_EN
  localparam int BLANK = 2;
`else
  localparam int BLANK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seven_segment;
  logic        frame_start;

  seg7_scan_driver #(
    .CYCLES_PER_SECOND(40),
    .SCAN_HZ(10),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits(digits),
    .digit_en(digit_en),
    .load(load),
    .an(an),
    .seven_segment(seven_segment),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [15:0] d;
    logic [3:0]  en;
  } load_t;

  load_t       loads[$];
  int          e = 0;
  int          checks = 0;
  int          failures = 0;
  logic [6:0]  seg_table [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", tag, e, got, exp);
    end
  endtask

  // Expected display after rising edge number n since reset release.
  task automatic model(input int n, output logic [3:0] x_an, output logic [6:0] x_seg,
                       output logic x_fs);
    int          k;
    int          slot;
    int          latch_edge;
    logic [15:0] d;
    logic [3:0]  en;
    logic [3:0]  nib;
    k    = n / DIV;
    slot = k % 4;
    d    = '0;
    en   = '0;
    if (k >= 4) begin
      latch_edge = (k / 4) * FRAME;
      foreach (loads[i]) begin
        if (loads[i].edge_no <= latch_edge) begin
          d  = loads[i].d;
          en = loads[i].en;
        end
      end
    end
    nib   = d[slot*4 +: 4];
    x_an  = 4'b1111;
    x_seg = 7'h7F;
    if (en[slot]) begin
      x_an[slot] = 1'b0;
      x_seg      = seg_table[nib];
    end
    if (k >= 1 && (n % DIV) < BLANK) begin
      x_an  = 4'b1111;
      x_seg = 7'h7F;
    end
    x_fs = (n > 0) && (n % FRAME == 0);
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] en);
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_fs;
    load     = ld;
    digits   = d;
    digit_en = en;
    if (ld) loads.push_back('{e + 1, d, en});
    @(posedge clk);
    e++;
    #1;
    model(e, x_an, x_seg, x_fs);
    check("an", 32'(an), 32'(x_an));
    check("seg", 32'(seven_segment), 32'(x_seg));
    check("frame_start", 32'(frame_start), 32'(x_fs));
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  ren;
    seg_table = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    #1 rst = 1'b1;
    #1;
    check("reset_an", 32'(an), 32'h0000_000F);
    check("reset_seg", 32'(seven_segment), 32'h0000_007F);
    check("reset_fs", 32'(frame_start), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e = 0;

    // Directed scenarios keyed by the edge at which the load is sampled.
    for (int i = 0; i < 112; i++) begin
      case (e + 1)
        2:       step(1'b1, 16'h1234, 4'hF);
        50:      step(1'b1, 16'hABCD, 4'b0101);
        70:      step(1'b1, 16'h1111, 4'hF);
        76:      step(1'b1, 16'h2222, 4'hF);
        96:      step(1'b1, 16'hFFFF, 4'hF);
        default: step(1'b0, 16'h0000, 4'h0);
      endcase
    end

    for (int i = 0; i < 400; i++) begin
      rd  = 16'($urandom);
      ren = 4'($urandom);
      step(($urandom_range(0, 5) == 0), rd, ren);
    end

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'h0000_000F);
    check("async_rst_seg", 32'(seven_segment), 32'h0000_007F);
    check("async_rst_fs", 32'(frame_start), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    e = 0;
    loads.delete();

    for (int i = 0; i < 200; i++) begin
      rd  = 16'($urandom);
      ren = 4'($urandom);
      step(($urandom_range(0, 3) == 0), rd, ren);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. Sits downstream of the LED/counter control logic: takes four hex nibbles plus per-digit enables and scans them onto `an`/`seven_segment`. It replaces the fixed single-digit `an = 4'b1110` scheme. Inputs are double-buffered so a value update never tears mid-frame.

Parameters:
- CYCLES_PER_SECOND, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. DIV = CYCLES_PER_SECOND/SCAN_HZ, integer division. DIV >= 2 is required; an elaboration-time check fails otherwise.
- BLANK_CYCLES, 16, ghost-blanking length in clk cycles. Used only with SEG_BLANK_EN. Must be < DIV.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- digits, input, 16, four hex nibbles; [3:0] is the rightmost digit (digit 0), [15:12] is digit 3.
- digit_en, input, 4, per-digit enable; 0 blanks that digit.
- load, input, 1, one-cycle strobe that captures digits/digit_en into the shadow register.
- an, output, 4, digit anodes, active-low; bit i is digit i.
- seven_segment, output, 7, segments, active-low; bit0=a … bit6=g.
- frame_start, output, 1, one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- **Reset (async, rst=1):**
  - prescaler=0, idx=0.
  - shadow and active registers = 0, including enables.
  - an=4'b1111, seven_segment=7'h7F, frame_start=0.
  - Effect is immediate, including mid-frame; no partial digit is left lit.
- **Prescaler:**
  - Counts 0..DIV-1 and wraps to 0.
  - tick=1 when prescaler==DIV-1.
- **Digit index:**
  - 2-bit idx advances on tick.
  - 3→0 wrap is natural modulo-4.
- **Shadow register:**
  - On load=1, shadow <= {digits, digit_en}.
  - Multiple loads within a frame: the last one wins.
- **Frame boundary** (tick while idx==3):
  - If load=1 in the same cycle, active <= the live inputs (bypass).
  - Otherwise active <= shadow.
  - The active register is never updated at any other time.
- **frame_start:** registered; asserted for exactly one cycle, the cycle after the frame-boundary tick. It is coincident with idx becoming 0 at the outputs.
- **Outputs:** registered, updated one cycle after the tick that changes idx, using the new idx and new active values.
  - an = all ones except bit idx = ~active_en[idx].
  - seven_segment = active_en[idx] ? hexdec(active_digit[idx]) : 7'h7F.
- **hexdec:** internal combinational 0–F table, active-low, a..g order.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- **Between ticks:** outputs hold steady.
- **First frame after reset:** shows blanks until the first frame boundary, even if load pulses earlier.

Optional Feature:
SEG_BLANK_EN.
- **Defined:** for BLANK_CYCLES cycles after each output update, an=4'b1111 and seven_segment=7'h7F. Normal drive then resumes until the next tick. This suppresses ghosting on digit change. frame_start timing is unchanged.
- **Undefined:** no blanking window; outputs drive continuously as above.

Test Plan:
1. Bench uses CYCLES_PER_SECOND=40, SCAN_HZ=10 (DIV=4). Apply reset → an=1111, seg=7F, frame_start=0. Assert rst asynchronously mid-scan → an=1111 within the same cycle window, no clk edge needed.
2. load digits=16'h1234, digit_en=4'hF. → Blanks until the first frame boundary. Then each digit is held for 4 cycles: an=1110/seg=19 ("4"), an=1101/seg=30 ("3"), an=1011/seg=24 ("2"), an=0111/seg=79 ("1"), repeating. frame_start pulses every 16 cycles.
3. digits=16'hABCD, digit_en=4'b0101. → Digits 0 and 2 show d=21 and b=03. Slots 1 and 3 show an=1111, seg=7F.
4. load 16'h1111 mid-frame, then 16'h2222 before the boundary. → Current frame unchanged; the next frame shows all "2" (seg=24).
5. load 16'hFFFF coincident with the frame-boundary tick. → The next frame shows F (seg=0E) immediately, via the bypass.
6. With SEG_BLANK_EN and BLANK_CYCLES=2. → After each digit change, 2 cycles of an=1111/seg=7F, then 2 cycles of normal drive. frame_start period is unchanged at 16 cycles.
